// File: rtl/frame_checker.sv
// Receive-side frame checker: collects 16 payload bytes, checks CRC-8,
// replays good frames from a local buffer and counts bad ones.
module frame_checker #(
  parameter int         FRAME_LEN = 16,
  parameter logic [7:0] POLY      = 8'h07
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_in_valid,
  input  logic [7:0] i_frame_data,
  input  logic       i_crc_valid,
  input  logic [7:0] i_crc,
  output logic       o_in_ready,
  output logic       o_out_valid,
  output logic [7:0] o_out_data,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [7:0] o_err_count
);

  localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    RECV, WAIT_CRC, CHECK, DRAIN, CLEAR
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_idx;
  logic [7:0] r_crc;
  logic       r_match;
  logic [7:0] r_buf [FRAME_LEN];

  logic [7:0] w_crc_next;
  logic       w_wr;

  function automatic logic [7:0] crc8_byte(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++)
      x = x[7] ? ((x << 1) ^ POLY) : (x << 1);
    return x;
  endfunction

  assign w_crc_next = crc8_byte(r_crc, i_frame_data);

  // A byte paired with an early crc beat is dropped (short frame)
  assign w_wr = (r_state == RECV) && i_in_valid &&
                (!i_crc_valid || (r_cnt == LAST));

  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_buf[r_cnt] <= i_frame_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= RECV;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_crc       <= '0;
      r_match     <= 1'b0;
      o_in_ready  <= 1'b1;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_count <= '0;
    end else begin
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      unique case (r_state)
        RECV: begin
          if (i_crc_valid) begin
            r_match    <= i_in_valid && (r_cnt == LAST) &&
                          (w_crc_next == i_crc);
            o_in_ready <= 1'b0;
            r_state    <= CHECK;
          end else if (i_in_valid) begin
            r_crc <= w_crc_next;
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == LAST)
              r_state <= WAIT_CRC;
          end
        end
        WAIT_CRC: begin
          if (i_crc_valid) begin
            r_match    <= (r_crc == i_crc);
            o_in_ready <= 1'b0;
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          o_frame_ok  <= r_match;
          o_frame_err <= !r_match;
          if (!r_match && (o_err_count != 8'hFF))
            o_err_count <= o_err_count + 8'd1;
          r_cnt   <= '0;
          r_crc   <= '0;
          r_idx   <= '0;
          r_state <= r_match ? DRAIN : CLEAR;
        end
        DRAIN: begin
          o_out_valid <= 1'b1;
          o_out_data  <= r_buf[r_idx];
          r_idx       <= r_idx + 4'd1;
          if (r_idx == LAST)
            r_state <= CLEAR;
        end
        CLEAR: begin
          o_out_valid <= 1'b0;
          o_in_ready  <= 1'b1;
          r_state     <= RECV;
        end
        default: r_state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_checker.sv
// Bench for frame_checker: a per-cycle expected-output schedule built from
// whole-frame decisions, checked every cycle, plus literal spot checks.
module tb_frame_checker;

  localparam int N = 8192;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_in_valid = 1'b0;
  logic [7:0] i_frame_data = '0;
  logic       i_crc_valid = 1'b0;
  logic [7:0] i_crc = '0;
  logic       o_in_ready;
  logic       o_out_valid;
  logic [7:0] o_out_data;
  logic       o_frame_ok;
  logic       o_frame_err;
  logic [7:0] o_err_count;

  frame_checker dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_in_valid(i_in_valid), .i_frame_data(i_frame_data),
    .i_crc_valid(i_crc_valid), .i_crc(i_crc),
    .o_in_ready(o_in_ready), .o_out_valid(o_out_valid),
    .o_out_data(o_out_data), .o_frame_ok(o_frame_ok),
    .o_frame_err(o_frame_err), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  bit run   = 0;

  bit         exp_ready [N];
  bit         exp_valid [N];
  bit         exp_ok    [N];
  bit         exp_err   [N];
  logic [7:0] exp_data  [N];
  int         m_err = 0;
  logic [7:0] mq[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    ntot++;
    if (a == e) npass++;
    else $display("FAIL %s @cyc %0d: got %0h want %0h", n, cyc, a, e);
  endtask

  // Bit-serial long division of the message by x^8+x^2+x+1
  function automatic logic [7:0] m_crc(input logic [7:0] q[$]);
    logic [7:0] r;
    logic fb;
    r = 8'h00;
    foreach (q[i])
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ q[i][b];
        r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return r;
  endfunction

  function automatic void clear_from(input int k);
    for (int t = k; t < N; t++) begin
      exp_ready[t] = 1; exp_valid[t] = 0;
      exp_ok[t] = 0; exp_err[t] = 0; exp_data[t] = '0;
    end
  endfunction

  // Frame decision sampled at edge e: all outputs laid out ahead of time
  function automatic void sched(input int e, input bit pass);
    int last;
    last = pass ? e + 17 : e + 1;
    for (int t = e; t <= last && t < N; t++) exp_ready[t] = 0;
    if (pass) begin
      exp_ok[e+1] = 1;
      for (int i = 0; i < 16; i++) begin
        exp_valid[e+2+i] = 1;
        exp_data[e+2+i] = mq[i];
      end
    end else exp_err[e+1] = 1;
    mq.delete();
  endfunction

  function automatic void model_beat(input logic v, input logic [7:0] d,
                                     input logic cv, input logic [7:0] c);
    int k;
    k = cyc;
    if (!exp_ready[k]) return;
    if (mq.size() == 16) begin
      if (cv) sched(k + 1, m_crc(mq) == c);
    end else if (cv) begin
      if (v && mq.size() == 15) begin
        mq.push_back(d);
        sched(k + 1, m_crc(mq) == c);
      end else sched(k + 1, 0);
    end else if (v) mq.push_back(d);
  endfunction

  always @(negedge i_clk) begin
    if (run) begin
      if (i_reset) begin
        m_err = 0;
        chk("rst_ready", o_in_ready, 1);
        chk("rst_valid", o_out_valid, 0);
        chk("rst_ok", o_frame_ok, 0);
        chk("rst_err", o_frame_err, 0);
        chk("rst_cnt", o_err_count, 0);
      end else begin
        if (exp_err[cyc] && m_err < 255) m_err++;
        chk("in_ready", o_in_ready, exp_ready[cyc]);
        chk("out_valid", o_out_valid, exp_valid[cyc]);
        chk("frame_ok", o_frame_ok, exp_ok[cyc]);
        chk("frame_err", o_frame_err, exp_err[cyc]);
        chk("err_count", o_err_count, m_err);
        if (exp_valid[cyc]) chk("out_data", o_out_data, exp_data[cyc]);
      end
    end
  end

  task automatic beat(input logic v, input logic [7:0] d,
                      input logic cv, input logic [7:0] c);
    i_in_valid = v; i_frame_data = d;
    i_crc_valid = cv; i_crc = c;
    model_beat(v, d, cv, c);
    @(posedge i_clk); #1;
    i_in_valid = 0; i_frame_data = '0;
    i_crc_valid = 0; i_crc = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(0, 8'h00, 0, 8'h00);
  endtask

  task automatic wait_ready();
    int b;
    b = 0;
    while (!exp_ready[cyc] && b < 100) begin
      idle(1); b++;
    end
    if (b >= 100) chk("ready_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [7:0] b[16], input logic [7:0] c,
                            input bit gaps, input bit merge, input bit extra);
    wait_ready();
    for (int i = 0; i < 16; i++) begin
      if (merge && i == 15) beat(1, b[i], 1, c);
      else beat(1, b[i], 0, 8'h00);
      if (gaps && i < 15) idle((i % 3) + 1);
    end
    if (!merge) begin
      if (extra) beat(1, 8'h5A, 0, 8'h00);
      beat(0, 8'h00, 1, c);
    end
  endtask

  task automatic do_reset();
    i_reset = 1;
    i_in_valid = 0; i_crc_valid = 0;
    clear_from(cyc);
    mq.delete();
    #1;
    chk("lit_rst_ready", o_in_ready, 1);
    chk("lit_rst_valid", o_out_valid, 0);
    chk("lit_rst_data", o_out_data, 0);
    chk("lit_rst_cnt", o_err_count, 0);
    @(posedge i_clk); #1;
    i_reset = 0;
  endtask

  logic [7:0] inc [16];
  logic [7:0] zer [16];
  logic [7:0] q[$];

  initial begin
    for (int i = 0; i < 16; i++) begin
      inc[i] = 8'(i + 1);
      zer[i] = 8'h00;
    end
    clear_from(0);
    run = 1;
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(inc[i]);
    chk("lit_model_crc_inc", m_crc(q), 8'hB0);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(8'h00);
    chk("lit_model_crc_zero", m_crc(q), 8'h00);

    repeat (2) @(posedge i_clk);
    #1;
    chk("lit_init_ready", o_in_ready, 1);
    chk("lit_init_data", o_out_data, 0);
    i_reset = 0;

    send_frame(inc, 8'hB0, 0, 0, 0);
    wait_ready();
    chk("lit_cnt_after_ok", o_err_count, 0);
    send_frame(inc, 8'hB1, 0, 0, 0);
    wait_ready();
    chk("lit_cnt_after_bad", o_err_count, 1);
    send_frame(zer, 8'h00, 0, 0, 0);
    send_frame(inc, 8'hB0, 1, 0, 0);

    wait_ready();
    for (int i = 0; i < 9; i++) beat(1, inc[i], 0, 8'h00);
    beat(0, 8'h00, 1, 8'hB0);
    send_frame(inc, 8'hB0, 0, 0, 0);

    send_frame(inc, 8'hB0, 0, 1, 0);
    while (!exp_ready[cyc]) beat(1, 8'hEE, 0, 8'h00);
    send_frame(inc, 8'hB0, 0, 0, 1);

    wait_ready();
    for (int i = 0; i < 7; i++) beat(1, inc[i], 0, 8'h00);
    i_in_valid = 1; i_frame_data = inc[7];
    do_reset();
    send_frame(inc, 8'hB0, 0, 0, 0);
    idle(6);
    do_reset();
    send_frame(inc, 8'hB0, 0, 0, 0);

    for (int f = 0; f < 300; f++) begin
      wait_ready();
      beat(0, 8'h00, 1, 8'h00);
    end
    wait_ready();
    idle(2);
    chk("lit_cnt_sat", o_err_count, 8'hFF);
    send_frame(inc, 8'hB0, 0, 0, 0);
    wait_ready();
    idle(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
